// File: rtl/nibble_serial_adder.sv
// Serial multi-word adder: one 4-bit RCA44 slice per clock, ripple carry held
// in a register between slices, valid/ready handshakes on operands and result.

module rca44 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;

  logic [3:0]       rca_s;
  logic             rca_co;

  rca44 u_rca44 (
    .a  (a_sh_q[3:0]),
    .b  (b_sh_q[3:0]),
    .ci (carry_q),
    .s  (rca_s),
    .co (rca_co)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[4*idx_q +: 4] = rca_s;
        carry_d = rca_co;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        if (idx_q == LAST) begin
          // idx parks at zero so it never exceeds the last slice number
          idx_d   = '0;
          cout_d  = rca_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  // operand shift registers are pure data and are always reloaded on accept
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule
